uart_prog_loader: RTL

//  Serial program loader for the easy6502 system. It sits between the serial_rxd
//  pin and the 6502 work RAM, on the 12 MHz CPU clock domain.
//  - Receives 8N1 UART bytes and writes them to RAM at LOAD_ADDR, LOAD_ADDR+1, ...
//  - Holds the CPU in reset while a load is in progress.
//  - Releases the CPU once the line has been idle for IDLE_BITS bit-times.

---
 rtl/uart_prog_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives 8N1 UART bytes on rxd, writes them to RAM from
// LOAD_ADDR upward and holds the 6502 in reset until the line has gone quiet.
module uart_prog_loader #(
    parameter int          CLK_HZ    = 12000000,
    parameter int          BAUD      = 115200,
    parameter logic [15:0] LOAD_ADDR = 16'h0600,
    parameter int          IDLE_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        cpu_reset,
    output logic        loading,
    output logic [15:0] byte_count,
    output logic        frame_err,
    output logic [1:0]  rx_state_o,
    output logic [1:0]  ld_state_o
);
    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [15:0] BIT_M1       = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1      = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] IDLE_M1      = 32'(IDLE_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_RUN} ld_state_t;

    logic [1:0]  sync_q;
    logic        rxs;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    ld_state_t   ld_state_q, ld_state_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic [15:0] base_count;

    assign rxs = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b11;
            rx_state_q   <= R_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            ld_state_q   <= L_IDLE;
            idle_cnt_q   <= '0;
            mem_addr_q   <= LOAD_ADDR;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            byte_count_q <= '0;
        end else begin
            sync_q       <= {sync_q[0], rxd};
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            ld_state_q   <= ld_state_d;
            idle_cnt_q   <= idle_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (!rxs) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = R_IDLE;
                    rx_valid_d  = rxs;
                    frame_err_d = !rxs;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // A byte arriving outside L_LOAD starts a new session, so it counts from zero.
    assign base_count = (ld_state_q == L_LOAD) ? byte_count_q : 16'd0;

    always_comb begin
        ld_state_d   = ld_state_q;
        idle_cnt_d   = idle_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        byte_count_d = byte_count_q;
        if (rx_valid_q) begin
            mem_we_d     = 1'b1;
            mem_wdata_d  = rx_shift_q;
            mem_addr_d   = LOAD_ADDR + base_count;
            byte_count_d = base_count + 16'd1;
            idle_cnt_d   = '0;
            ld_state_d   = L_LOAD;
        end else if (ld_state_q == L_LOAD && rx_state_q == R_IDLE) begin
            if (idle_cnt_q == IDLE_M1) begin
                idle_cnt_d = '0;
                ld_state_d = L_RUN;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign byte_count = byte_count_q;
    assign frame_err  = frame_err_q;
    assign cpu_reset  = (ld_state_q != L_RUN);
    assign loading    = (ld_state_q == L_LOAD);
    assign rx_state_o = rx_state_q;
    assign ld_state_o = ld_state_q;
endmodule
